// File: rtl/program_loader.sv
// program_loader: frames a length/payload/checksum byte stream into memory and releases the CPU on a clean load.
module program_loader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, LEN, LOAD, CSUM, DONE, ERROR} state_t;
  localparam logic [DATA_W-1:0] DEPTH_B = DATA_W'(DEPTH);
  state_t            state_q, state_d;
  logic [ADDR_W:0]   idx_q, idx_d, len_q, len_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              in_ready_q, in_ready_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_rst_q, cpu_rst_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              xfer;
  assign xfer      = in_valid && in_ready_q;
  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rst   = cpu_rst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    sum_d       = sum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rst_d   = cpu_rst_q;
    done_d      = done_q;
    err_d       = err_q;
    case (state_q)
      IDLE, DONE, ERROR: if (start) begin
        state_d   = LEN;
        cpu_rst_d = 1'b1;
        done_d    = 1'b0;
        err_d     = 1'b0;
        sum_d     = '0;
        idx_d     = '0;
      end
      LEN: if (xfer) begin
        sum_d   = in_data;
        len_d   = in_data[ADDR_W:0];
        state_d = (in_data == '0 || in_data > DEPTH_B) ? ERROR : LOAD;
        err_d   = (in_data == '0 || in_data > DEPTH_B);
      end
      LOAD: if (xfer) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = idx_q[ADDR_W-1:0];
        mem_wdata_d = in_data;
        sum_d       = sum_q + in_data;
        idx_d       = idx_q + 1'b1;
        state_d     = (idx_d == len_q) ? CSUM : LOAD;
      end
      CSUM: if (xfer) begin
        state_d   = (DATA_W'(sum_q + in_data) == '0) ? DONE : ERROR;
        done_d    = (state_d == DONE);
        err_d     = (state_d == ERROR);
        cpu_rst_d = (state_d == ERROR);
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == LEN) || (state_d == LOAD) || (state_d == CSUM);
    busy_d     = in_ready_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      sum_q       <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rst_q   <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rst_q   <= cpu_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end
endmodule
